// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: pipeline, interrupt and CSR-file signals.
// master = sequencer side, slave = pipeline/CSR side.
interface trap_sequencer_if;
  logic        exc_valid;
  logic [5:0]  exc_code;
  logic [31:0] exc_pc;
  logic        irq_external;
  logic        irq_software;
  logic        irq_timer;
  logic        mstatus_mie;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mret_valid;
  logic [31:0] next_pc;
  logic        flush_req;
  logic        flush_ack;
  logic        exc_ack;
  logic        mret_ack;
  logic        trap_take;
  logic        trap_ret;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    input  exc_valid, exc_code, exc_pc,
    input  irq_external, irq_software, irq_timer,
    input  mstatus_mie, mie, mtvec, mepc,
    input  mret_valid, next_pc, flush_ack,
    output flush_req, exc_ack, mret_ack,
    output trap_take, trap_ret,
    output trap_cause, trap_epc,
    output redirect_valid, redirect_pc, busy
  );

  modport slave (
    output exc_valid, exc_code, exc_pc,
    output irq_external, irq_software, irq_timer,
    output mstatus_mie, mie, mtvec, mepc,
    output mret_valid, next_pc, flush_ack,
    input  flush_req, exc_ack, mret_ack,
    input  trap_take, trap_ret,
    input  trap_cause, trap_epc,
    input  redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: arbitrate, drain, commit, redirect.
// All outputs are flops decoded from the next state.
module trap_sequencer #(
  parameter bit VECTORED_EN = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  trap_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, DRAIN, COMMIT, REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    K_EXC, K_IRQ, K_RET
  } kind_t;

  state_t      state;
  state_t      state_nx;
  kind_t       kind;
  kind_t       kind_d;
  logic [31:0] cause;
  logic [31:0] cause_d;
  logic [31:0] epc;
  logic [31:0] epc_d;
  logic [31:0] rpc;
  logic [31:0] rpc_d;
  logic [31:0] base;
  logic [4:0]  pick;
  logic        ext_en;
  logic        sw_en;
  logic        tmr_en;
  logic        any_src;

  logic        flush_req;
  logic        exc_ack;
  logic        mret_ack;
  logic        trap_take;
  logic        trap_ret;
  logic        redirect_valid;
  logic        busy;

  logic unused_bits;
  assign unused_bits = ^{bus.mie[31:12], bus.mie[10:8],
                         bus.mie[6:4], bus.mie[2:0],
                         bus.mepc[1:0]};

  assign ext_en = bus.mstatus_mie & bus.irq_external
                & bus.mie[11];
  assign sw_en  = bus.mstatus_mie & bus.irq_software
                & bus.mie[3];
  assign tmr_en = bus.mstatus_mie & bus.irq_timer
                & bus.mie[7];

  // one-hot priority pick: exc > ext > sw > timer > mret
  assign pick[0] = bus.exc_valid;
  assign pick[1] = ext_en & ~bus.exc_valid;
  assign pick[2] = sw_en & ~bus.exc_valid & ~ext_en;
  assign pick[3] = tmr_en & ~bus.exc_valid & ~ext_en
                 & ~sw_en;
  assign pick[4] = bus.mret_valid & ~bus.exc_valid
                 & ~ext_en & ~sw_en & ~tmr_en;
  assign any_src = |pick;

  // decode the winning source into kind, cause and EPC
  always_comb begin
    kind_d  = K_RET;
    cause_d = 32'd0;
    epc_d   = 32'd0;
    unique case (1'b1)
      pick[0]: begin
        kind_d  = K_EXC;
        cause_d = {26'd0, bus.exc_code};
        epc_d   = bus.exc_pc;
      end
      pick[1]: begin
        kind_d  = K_IRQ;
        cause_d = {1'b1, 25'd0, 6'd11};
        epc_d   = bus.next_pc;
      end
      pick[2]: begin
        kind_d  = K_IRQ;
        cause_d = {1'b1, 25'd0, 6'd3};
        epc_d   = bus.next_pc;
      end
      pick[3]: begin
        kind_d  = K_IRQ;
        cause_d = {1'b1, 25'd0, 6'd7};
        epc_d   = bus.next_pc;
      end
      default: begin
        kind_d  = K_RET;
        cause_d = 32'd0;
        epc_d   = 32'd0;
      end
    endcase
  end

  // redirect target from the CSR values seen leaving COMMIT
  always_comb begin
    base  = {bus.mtvec[31:2], 2'b00};
    rpc_d = base;
    if (kind == K_RET) begin
      rpc_d = {bus.mepc[31:2], 2'b00};
    end else if (kind == K_IRQ && VECTORED_EN
                 && bus.mtvec[1:0] == 2'b01) begin
      rpc_d = base + {24'd0, cause[5:0], 2'b00};
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (any_src) state_nx = DRAIN;
      DRAIN:    if (bus.flush_ack) state_nx = COMMIT;
      COMMIT:   state_nx = REDIRECT;
      REDIRECT: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // state register and latched trap fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      kind  <= K_EXC;
      cause <= 32'd0;
      epc   <= 32'd0;
      rpc   <= 32'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_src) begin
        kind  <= kind_d;
        cause <= cause_d;
        epc   <= epc_d;
      end
      if (state == COMMIT) begin
        rpc <= rpc_d;
      end
    end
  end

  // registered pulse/level outputs decoded from next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_req      <= 1'b0;
      exc_ack        <= 1'b0;
      mret_ack       <= 1'b0;
      trap_take      <= 1'b0;
      trap_ret       <= 1'b0;
      redirect_valid <= 1'b0;
      busy           <= 1'b0;
    end else begin
      flush_req      <= state_nx == DRAIN;
      exc_ack        <= state_nx == COMMIT
                      && kind == K_EXC;
      mret_ack       <= state_nx == COMMIT
                      && kind == K_RET;
      trap_take      <= state_nx == COMMIT
                      && kind != K_RET;
      trap_ret       <= state_nx == COMMIT
                      && kind == K_RET;
      redirect_valid <= state_nx == REDIRECT;
      busy           <= state_nx != IDLE;
    end
  end

  assign bus.flush_req      = flush_req;
  assign bus.exc_ack        = exc_ack;
  assign bus.mret_ack       = mret_ack;
  assign bus.trap_take      = trap_take;
  assign bus.trap_ret       = trap_ret;
  assign bus.trap_cause     = cause;
  assign bus.trap_epc       = epc;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = rpc;
  assign bus.busy           = busy;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer.
// Directed scenarios plus randomized traffic against a source-level model.
module tb_trap_sequencer;

  logic clk;
  logic reset_n;
  int   vec;
  int   miss;

  trap_sequencer_if bus();

  trap_sequencer #(.VECTORED_EN(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: which source wins and what the CSR file / PC should see.
  // Returns 0 none, 1 exception, 2 interrupt, 3 mret.
  function automatic int predict(output logic [31:0] c,
                                 output logic [31:0] e,
                                 output logic [31:0] r);
    int codes[3];
    logic [2:0] pend;
    logic [31:0] base;
    codes[0] = 11;
    codes[1] = 3;
    codes[2] = 7;
    pend[0] = bus.irq_external & bus.mie[11];
    pend[1] = bus.irq_software & bus.mie[3];
    pend[2] = bus.irq_timer & bus.mie[7];
    if (!bus.mstatus_mie) pend = 3'b000;
    base = bus.mtvec & 32'hFFFF_FFFC;
    c = 0;
    e = 0;
    r = 0;
    if (bus.exc_valid) begin
      c = {26'd0, bus.exc_code};
      e = bus.exc_pc;
      r = base;
      return 1;
    end
    for (int i = 0; i < 3; i++) begin
      if (pend[i]) begin
        c = 32'h8000_0000 + codes[i];
        e = bus.next_pc;
        r = base;
        if (bus.mtvec % 4 == 1) r = base + 32'(codes[i] * 4);
        return 2;
      end
    end
    if (bus.mret_valid) begin
      r = bus.mepc & 32'hFFFF_FFFC;
      return 3;
    end
    return 0;
  endfunction

  task automatic clear_inputs();
    bus.exc_valid    = 0;
    bus.exc_code     = 0;
    bus.exc_pc       = 0;
    bus.irq_external = 0;
    bus.irq_software = 0;
    bus.irq_timer    = 0;
    bus.mstatus_mie  = 0;
    bus.mie          = 0;
    bus.mtvec        = 0;
    bus.mepc         = 0;
    bus.mret_valid   = 0;
    bus.next_pc      = 0;
    bus.flush_ack    = 0;
  endtask

  // One full trap sequence starting from an IDLE cycle with a source set.
  task automatic run_sequence(input int dly);
    logic [31:0] ec, ee, er;
    logic [5:0] got, want;
    int k;
    k = predict(ec, ee, er);
    @(negedge clk);
    vec++;
    if (bus.flush_req !== 1'b1 || bus.busy !== 1'b1)
      begin miss++; $display("FAIL drain_entry got %b%b want 11",
        bus.flush_req, bus.busy); end
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      vec++;
      if (bus.flush_req !== 1'b1 || bus.trap_take !== 1'b0
          || bus.redirect_valid !== 1'b0)
        begin miss++; $display("FAIL drain_hold got %b%b%b want 100",
          bus.flush_req, bus.trap_take, bus.redirect_valid); end
    end
    bus.flush_ack = 1;
    @(negedge clk);
    bus.flush_ack = 0;
    got  = {bus.trap_take, bus.trap_ret, bus.exc_ack,
            bus.mret_ack, bus.flush_req, bus.redirect_valid};
    want = {k != 3, k == 3, k == 1, k == 3, 1'b0, 1'b0};
    vec++;
    if (got !== want)
      begin miss++; $display("FAIL commit_pulses got %b want %b",
        got, want); end
    if (k != 3) begin
      vec++;
      if (bus.trap_cause !== ec)
        begin miss++; $display("FAIL cause got %h want %h",
          bus.trap_cause, ec); end
      vec++;
      if (bus.trap_epc !== ee)
        begin miss++; $display("FAIL epc got %h want %h",
          bus.trap_epc, ee); end
    end
    if (k == 1) bus.exc_valid = 0;
    if (k == 3) bus.mret_valid = 0;
    if (k == 2) begin
      if (ec[5:0] == 6'd11) bus.irq_external = 0;
      if (ec[5:0] == 6'd3)  bus.irq_software = 0;
      if (ec[5:0] == 6'd7)  bus.irq_timer    = 0;
    end
    @(negedge clk);
    got  = {bus.trap_take, bus.trap_ret, bus.exc_ack,
            bus.mret_ack, bus.flush_req, bus.redirect_valid};
    vec++;
    if (got !== 6'b000001)
      begin miss++; $display("FAIL redirect_pulses got %b want 000001",
        got); end
    vec++;
    if (bus.redirect_pc !== er)
      begin miss++; $display("FAIL redirect_pc got %h want %h",
        bus.redirect_pc, er); end
    @(negedge clk);
    vec++;
    if (bus.busy !== 1'b0 || bus.redirect_valid !== 1'b0
        || bus.flush_req !== 1'b0)
      begin miss++; $display("FAIL idle_gap got %b%b%b want 000",
        bus.busy, bus.redirect_valid, bus.flush_req); end
  endtask

  task automatic drain_all(input int dly);
    logic [31:0] a, b, c;
    int guard;
    guard = 0;
    while (predict(a, b, c) != 0 && guard < 16) begin
      run_sequence(dly);
      guard++;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    repeat (3) @(negedge clk);
    vec++;
    if ({bus.flush_req, bus.exc_ack, bus.mret_ack, bus.trap_take,
         bus.trap_ret, bus.redirect_valid, bus.busy, bus.trap_cause,
         bus.trap_epc, bus.redirect_pc} !== '0)
      begin miss++; $display("FAIL reset_outputs got busy=%b cause=%h want 0",
        bus.busy, bus.trap_cause); end
    reset_n = 1;
    @(negedge clk);
    vec++;
    if (bus.busy !== 1'b0)
      begin miss++; $display("FAIL reset_idle got %b want 0", bus.busy); end
  endtask

  task automatic test_exception();
    bus.exc_valid = 1;
    bus.exc_code  = 6'd2;
    bus.exc_pc    = 32'h100;
    bus.mtvec     = 32'h8000_0001;
    run_sequence(2);
  endtask

  task automatic test_vectored_irq();
    bus.mstatus_mie = 1;
    bus.mie         = 32'h80;
    bus.irq_timer   = 1;
    bus.next_pc     = 32'h204;
    bus.mtvec       = 32'h1001;
    run_sequence(0);
    bus.mie          = 32'h800;
    bus.irq_external = 1;
    bus.mtvec        = 32'hFFFF_FFF1;
    run_sequence(1);
    bus.mie          = 32'h8;
    bus.irq_software = 1;
    bus.mtvec        = 32'h4000_0000;
    run_sequence(0);
  endtask

  task automatic test_priority();
    bus.mstatus_mie  = 1;
    bus.mie          = 32'h888;
    bus.mtvec        = 32'h3001;
    bus.exc_valid    = 1;
    bus.exc_code     = 6'd13;
    bus.exc_pc       = 32'h440;
    bus.next_pc      = 32'h444;
    bus.irq_external = 1;
    bus.irq_timer    = 1;
    drain_all(1);
    clear_inputs();
  endtask

  task automatic test_masking();
    bus.irq_timer   = 1;
    bus.mie         = 32'hFFFF_FFFF;
    bus.mstatus_mie = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vec++;
      if (bus.busy !== 1'b0)
        begin miss++; $display("FAIL mask_mie got %b want 0", bus.busy); end
    end
    bus.mstatus_mie = 1;
    bus.mie         = 32'hFFFF_FF7F;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vec++;
      if (bus.busy !== 1'b0)
        begin miss++; $display("FAIL mask_bit got %b want 0", bus.busy); end
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_mret();
    bus.mret_valid = 1;
    bus.mepc       = 32'h2003;
    run_sequence(1);
    bus.mret_valid = 1;
    bus.exc_valid  = 1;
    bus.exc_code   = 6'd11;
    bus.exc_pc     = 32'h5000;
    bus.mtvec      = 32'h600;
    drain_all(0);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    bus.exc_valid = 1;
    bus.exc_code  = 6'd4;
    bus.exc_pc    = 32'h77C;
    bus.mtvec     = 32'h900;
    @(negedge clk);
    vec++;
    if (bus.flush_req !== 1'b1)
      begin miss++; $display("FAIL rst_pre got %b want 1", bus.flush_req); end
    reset_n = 0;
    #1;
    vec++;
    if ({bus.flush_req, bus.exc_ack, bus.mret_ack, bus.trap_take,
         bus.trap_ret, bus.redirect_valid, bus.busy, bus.trap_cause,
         bus.trap_epc, bus.redirect_pc} !== '0)
      begin miss++; $display("FAIL rst_async got busy=%b cause=%h want 0",
        bus.busy, bus.trap_cause); end
    bus.flush_ack = 1;
    @(negedge clk);
    vec++;
    if (bus.trap_take !== 1'b0 || bus.busy !== 1'b0)
      begin miss++; $display("FAIL rst_hold got %b%b want 00",
        bus.trap_take, bus.busy); end
    bus.flush_ack = 0;
    reset_n = 1;
    run_sequence(1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      clear_inputs();
      bus.exc_valid    = ($urandom_range(0, 3) == 0);
      bus.exc_code     = 6'($urandom);
      bus.exc_pc       = $urandom & 32'hFFFF_FFFC;
      bus.irq_external = 1'($urandom);
      bus.irq_software = 1'($urandom);
      bus.irq_timer    = 1'($urandom);
      bus.mstatus_mie  = ($urandom_range(0, 3) != 0);
      bus.mie          = $urandom;
      bus.mtvec        = $urandom;
      if ($urandom_range(0, 1) == 1)
        bus.mtvec = {bus.mtvec[31:2], 2'b01};
      bus.mepc         = $urandom;
      bus.mret_valid   = 1'($urandom);
      bus.next_pc      = $urandom & 32'hFFFF_FFFC;
      drain_all($urandom_range(0, 3));
      @(negedge clk);
      vec++;
      if (bus.busy !== 1'b0)
        begin miss++; $display("FAIL rand_quiet got %b want 0", bus.busy); end
    end
    clear_inputs();
  endtask

  initial begin
    vec = 0;
    miss = 0;
    reset_n = 0;
    clear_inputs();
    test_reset();
    test_exception();
    test_vectored_irq();
    clear_inputs();
    @(negedge clk);
    test_priority();
    test_masking();
    test_mret();
    @(negedge clk);
    test_reset_mid();
    clear_inputs();
    @(negedge clk);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
